// File: rtl/clock_disp_pkg.sv
// Shared constants, FSM state type and segment decoder for the clock display.
package clock_disp_pkg;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Digit codes: 0..9 are the decimal values themselves
    localparam logic [3:0] DIG_DASH  = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } disp_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        if (d <= 4'd9)
            s = SEG_DIGIT[d];
        else if (d == DIG_DASH)
            s = SEG_DASH;
        return s;
    endfunction

endpackage

// File: rtl/clock_display_scan_bin2bcd.sv
// Iterative double-dabble: one add-3/shift step per clock into an 8-bit BCD
// scratch. start loads the operand; done is high during the cycle whose edge
// performs the final shift, so bcd holds the result from the next cycle on.
module bin2bcd_iter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         done,
    output logic [7:0]   bcd
);
    // W >= 2, so a W-1 count fits in clog2(W) bits
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic          active;
    logic [CW-1:0] cnt;
    logic [W-1:0]  sh;
    logic [7:0]    adj;

    function automatic logic [7:0] add3(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = v[7:4];
        lo = v[3:0];
        if (hi >= 4'd5) hi = hi + 4'd3;
        if (lo >= 4'd5) lo = lo + 4'd3;
        return {hi, lo};
    endfunction

    assign adj  = add3(bcd);
    assign done = active && (cnt == LAST);

    // Step counter: a restart always wins over a conversion in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
        end else if (active) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) active <= 1'b0;
        end
    end

    // Scratch shift register: correct nibbles, then shift the next operand bit in
    always_ff @(posedge clk) begin
        if (start) begin
            bcd <= '0;
            sh  <= bin;
        end else if (active) begin
            bcd <= {adj[6:0], sh[W-1]};
            sh  <= sh << 1;
        end
    end

endmodule

// File: rtl/clock_display_scan.sv
// Display front end for the 12-hour clock core: snapshots the time on a
// strobe, converts hours/minutes to BCD, and scans a 4-digit HH:MM display.
module clock_display_scan
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       time_valid,
    input  logic [3:0] hours,
    input  logic       pm,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] dig_en,
    output logic       pm_led,
    output logic       busy
);
    localparam int SC_W = $clog2(SCAN_DIV);

    disp_state_t state, state_nxt;
    logic        start;
    logic        use_pend;
    logic [3:0]  src_hours, snap_hours, pend_hours;
    logic [5:0]  src_min, snap_min, pend_min;
    logic        src_pm, snap_pm, pend_pm;
    logic        src_sec0, snap_sec0, pend_sec0;
    logic        pend_vld;
    logic        min_done, unused_hrs_done;
    logic [7:0]  min_bcd, hrs_bcd;
    logic        hrs_ok, min_ok;
    logic [3:0]  dig_r   [0:3];
    logic [3:0]  dig_nxt [0:3];
    logic        colon_r, colon_nxt, pm_nxt;
    logic [3:0]  pos, pos_nxt, cur_dig;
    logic [SC_W-1:0] scan_cnt;
    logic        scan_wrap;
    logic        unused_sec;

    assign unused_sec = ^seconds[5:1];
    assign busy = (state != IDLE);

    // A restart out of COMMIT uses the live strobe if present (newest wins), else the pending buffer
    assign use_pend  = (state == COMMIT) && !time_valid;
    assign src_hours = use_pend ? pend_hours : hours;
    assign src_min   = use_pend ? pend_min   : minutes;
    assign src_pm    = use_pend ? pend_pm    : pm;
    assign src_sec0  = use_pend ? pend_sec0  : seconds[0];

    bin2bcd_iter #(.W(4)) u_hrs (
        .clk(clk), .rst(rst), .start(start), .bin(src_hours),
        .done(unused_hrs_done), .bcd(hrs_bcd)
    );

    bin2bcd_iter #(.W(6)) u_min (
        .clk(clk), .rst(rst), .start(start), .bin(src_min),
        .done(min_done), .bcd(min_bcd)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state and converter start
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: if (time_valid) begin
                start     = 1'b1;
                state_nxt = CONV;
            end
            CONV: if (min_done) state_nxt = COMMIT;
            COMMIT: if (time_valid || pend_vld) begin
                start     = 1'b1;
                state_nxt = CONV;
            end else begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot of the time being converted, taken whenever a conversion starts
    always_ff @(posedge clk) begin
        if (start) begin
            snap_hours <= src_hours;
            snap_min   <= src_min;
            snap_pm    <= src_pm;
            snap_sec0  <= src_sec0;
        end
    end

    // One-deep pending buffer for strobes arriving mid-conversion
    always_ff @(posedge clk) begin
        if (rst)                               pend_vld <= 1'b0;
        else if (state == CONV && time_valid)  pend_vld <= 1'b1;
        else if (state == COMMIT)              pend_vld <= 1'b0;
        if (state == CONV && time_valid) begin
            pend_hours <= hours;
            pend_min   <= minutes;
            pend_pm    <= pm;
            pend_sec0  <= seconds[0];
        end
    end

    assign hrs_ok = (snap_hours != 4'd0) && (snap_hours <= 4'd12);
    assign min_ok = (snap_min <= 6'd59);

    // Digit values after this edge: new time on COMMIT, otherwise held
    always_comb begin
        for (int i = 0; i < 4; i++) dig_nxt[i] = dig_r[i];
        colon_nxt = colon_r;
        pm_nxt    = pm_led;
        if (state == COMMIT) begin
            dig_nxt[3] = !hrs_ok ? DIG_DASH :
                         (snap_hours < 4'd10) ? DIG_BLANK : hrs_bcd[7:4];
            dig_nxt[2] = !hrs_ok ? DIG_DASH : hrs_bcd[3:0];
            dig_nxt[1] = !min_ok ? DIG_DASH : min_bcd[7:4];
            dig_nxt[0] = !min_ok ? DIG_DASH : min_bcd[3:0];
            colon_nxt  = ~snap_sec0;
            pm_nxt     = snap_pm;
        end
    end

    // Committed display registers, updated atomically
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_r   <= '{default: DIG_BLANK};
            colon_r <= 1'b0;
            pm_led  <= 1'b0;
        end else begin
            dig_r   <= dig_nxt;
            colon_r <= colon_nxt;
            pm_led  <= pm_nxt;
        end
    end

    assign scan_wrap = (scan_cnt == SC_W'(SCAN_DIV - 1));
    assign pos_nxt   = (en && scan_wrap) ? {pos[2:0], pos[3]} : pos;

    // Digit code for the position that will be enabled after this edge
    always_comb begin
        cur_dig = dig_nxt[0];
        case (pos_nxt)
            4'b0010: cur_dig = dig_nxt[1];
            4'b0100: cur_dig = dig_nxt[2];
            4'b1000: cur_dig = dig_nxt[3];
            default: cur_dig = dig_nxt[0];
        endcase
    end

    // Scan counter, digit rotation and registered pin outputs (seg/dp aligned with dig_en)
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            pos      <= 4'b0001;
            dig_en   <= 4'b0001;
            seg      <= SEG_BLANK;
            dp       <= 1'b0;
        end else begin
            pos <= pos_nxt;
            if (en) begin
                scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
                dig_en   <= pos_nxt;
                seg      <= seg_decode(cur_dig);
                dp       <= colon_nxt & pos_nxt[2];
            end else begin
                dig_en <= 4'b0000;
                seg    <= SEG_BLANK;
                dp     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// Testbench for clock_display_scan: directed strobes, scoreboard of expected
// display contents, and a monitor that checks every scan cycle after a commit.
module tb_clock_display_scan;

    logic       clk = 1'b0;
    logic       rst, en, time_valid, pm;
    logic [3:0] hours;
    logic [5:0] minutes, seconds;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig_en;
    logic       pm_led, busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [27:0] segs;   // {pos3, pos2, pos1, pos0} segment patterns
        logic        pm;
        logic        colon;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    clock_display_scan #(.SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .time_valid(time_valid),
        .hours(hours), .pm(pm), .minutes(minutes), .seconds(seconds),
        .seg(seg), .dp(dp), .dig_en(dig_en), .pm_led(pm_led), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0,
                                input logic p, input logic c);
        exp_t e;
        e.segs  = {s3, s2, s1, s0};
        e.pm    = p;
        e.colon = c;
        return e;
    endfunction

    // ---------------- monitor ----------------
    exp_t        cur;
    bit          in_win  = 0;
    int          wn      = 0;
    bit          win_bad = 0;
    string       bad_what;
    logic [31:0] bad_act, bad_req;

    task automatic note(input string what, input logic [31:0] a, input logic [31:0] r);
        if (!win_bad) begin
            win_bad  = 1;
            bad_what = what;
            bad_act  = a;
            bad_req  = r;
        end
    endtask

    task automatic close_win();
        total++;
        if (win_bad) begin
            bad++;
            $display("FAIL display_%s actual=%0h required=%0h", bad_what, bad_act, bad_req);
        end
        in_win = 0;
    endtask

    initial begin
        int run;
        int idx;
        logic [6:0] es;
        logic       edp;
        run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run    = 0;
                in_win = 0;
                continue;
            end
            if (in_win) begin
                case (dig_en)
                    4'b0001: idx = 0;
                    4'b0010: idx = 1;
                    4'b0100: idx = 2;
                    4'b1000: idx = 3;
                    default: idx = -1;
                endcase
                if (idx < 0) begin
                    note("dig_en", 32'(dig_en), 32'h0);
                end else begin
                    es  = cur.segs[idx*7 +: 7];
                    edp = (idx == 2) ? cur.colon : 1'b0;
                    if (seg !== es) note("seg", {idx[3:0], 5'b0, seg}, {idx[3:0], 5'b0, es});
                    if (dp !== edp) note("dp", {idx[3:0], 3'b0, dp}, {idx[3:0], 3'b0, edp});
                end
                if (pm_led !== cur.pm) note("pm_led", 32'(pm_led), 32'(cur.pm));
                wn++;
                if (wn == 16) close_win();
            end
            if (busy === 1'b1) run++;
            else               run = 0;
            if (run == 7) begin
                run = 0;
                if (in_win) close_win();
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_commit actual=commit required=none");
                end else begin
                    cur     = sb.pop_front();
                    in_win  = 1;
                    wn      = 0;
                    win_bad = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic strobe(input logic [3:0] h, input logic p, input logic [5:0] m, input logic [5:0] s);
        @(posedge clk); #1;
        hours = h; pm = p; minutes = m; seconds = s; time_valid = 1'b1;
        @(posedge clk); #1;
        time_valid = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
        end
    endtask

    initial begin
        int n;
        logic [3:0] prev, held;
        bit blank_ok;

        rst = 1'b1; en = 1'b1; time_valid = 1'b0;
        hours = 4'd0; pm = 1'b0; minutes = 6'd0; seconds = 6'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state and idle scan rotation with blank digits
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_pm_led", 32'(pm_led), 32'h0);
        check("rst_dp", 32'(dp), 32'h0);
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("rot_dig_en_%0d", k), 32'(dig_en), 32'(4'b0001 << ((k / 4) % 4)));
            check($sformatf("rot_seg_%0d", k), 32'(seg), 32'h0);
        end

        // 3:07 AM, sec=10
        sb.push_back(mk(7'h00, 7'h4F, 7'h3F, 7'h07, 1'b0, 1'b1));
        strobe(4'd3, 1'b0, 6'd7, 6'd10);
        busy_len(n);
        check("busy_len_307", 32'(n), 32'd7);
        repeat (20) @(negedge clk);

        // 12:59 PM, sec=11
        sb.push_back(mk(7'h06, 7'h5B, 7'h6D, 7'h6F, 1'b1, 1'b0));
        strobe(4'd12, 1'b1, 6'd59, 6'd11);
        busy_len(n);
        check("busy_len_1259", 32'(n), 32'd7);
        repeat (20) @(negedge clk);

        // hours=0, minutes=60: all dashes
        sb.push_back(mk(7'h40, 7'h40, 7'h40, 7'h40, 1'b0, 1'b1));
        strobe(4'd0, 1'b0, 6'd60, 6'd0);
        repeat (30) @(negedge clk);

        // hours=13, minutes=30: "--30"
        sb.push_back(mk(7'h40, 7'h40, 7'h4F, 7'h3F, 1'b1, 1'b0));
        strobe(4'd13, 1'b1, 6'd30, 6'd1);
        repeat (30) @(negedge clk);

        // 1:00 at N, 2:00 at N+2, 3:00 at N+4: 1:00 then 3:00, no idle gap
        sb.push_back(mk(7'h00, 7'h06, 7'h3F, 7'h3F, 1'b1, 1'b1));
        sb.push_back(mk(7'h00, 7'h4F, 7'h3F, 7'h3F, 1'b1, 1'b1));
        strobe(4'd1, 1'b1, 6'd0, 6'd2);
        strobe(4'd2, 1'b1, 6'd0, 6'd2);
        strobe(4'd3, 1'b1, 6'd0, 6'd4);
        busy_len(n);
        check("busy_len_b2b", 32'(n), 32'd10);
        repeat (20) @(negedge clk);

        // en=0 for 20 cycles, entered right after a rotation
        n = 0;
        @(negedge clk);
        prev = dig_en;
        while (dig_en === prev && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rotation_seen", 32'(n < 20), 32'h1);
        held = dig_en;
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("en0_outputs_%0d", k), {20'h0, seg, dp, dig_en}, 32'h0);
        end
        en = 1'b1;
        @(negedge clk);
        check("en_resume_dig_en", 32'(dig_en), 32'(held));

        // rst at CONV cycle 3
        strobe(4'd5, 1'b0, 6'd5, 6'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_dig_en", 32'(dig_en), 32'h1);
        check("midrst_pm_led", 32'(pm_led), 32'h0);
        check("midrst_seg", 32'(seg), 32'h0);
        blank_ok = 1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (seg !== 7'h00 || dp !== 1'b0 || busy !== 1'b0) blank_ok = 0;
        end
        check("midrst_blank_scan", 32'(blank_ok), 32'h1);
        repeat (10) @(negedge clk);

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
